uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin scheduler that shares the single UART transmitter between NUM_REQ byte-stream requesters (e.g. CPU TXD register path, debug logger, boot-status reporter). It sits between the requesters and the UART core's `data_tx`/`data_tx_wr`/`data_tx_ack` port, gated by the CR `tx_enable` bit. Grants are packet-locked: a granted requester owns the transmitter until it sends `req_last` or hits MAX_BURST bytes. Every byte is sent only after the previous one is acknowledged.

## Interface
- NUM_REQ, 2: number of requesters, 2..8.
- MAX_BURST, 16: max bytes per grant before forced rotation, 1..255.
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous, active-low; clock is clk.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  byte for requester i at [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of a packet, qualified by valid.
- req_ready  out  NUM_REQ  one-hot byte-accept strobe; the byte transfers on valid & ready.
- tx_enable  in  1  CR.tx_enable.
- tx_busy  in  1  UART core is shifting.
- data_tx  out  8  byte to the UART core.
- data_tx_wr  out  1  one-cycle write strobe.
- data_tx_ack  in  1  one-cycle pulse; the core has taken the byte and is ready for the next.
- grant  out  NUM_REQ  one-hot current owner; 0 when idle.
- active  out  1  a grant is held.

## Operation
- FSM states: IDLE, ISSUE, STROBE, WAIT.
- **IDLE**
  - Leaves only if tx_enable=1 and |req_valid.
  - The winner is the first set req_valid bit scanning upward (with wrap) from rr_ptr+1.
  - Next cycle: grant and active are registered, burst count=0, state moves to ISSUE.
- **ISSUE**
  - When req_valid[g] & tx_enable & !tx_busy:
    - req_ready[g]=1 combinationally for one cycle.
    - data_tx<=req_data[g]; last_q<=req_last[g]; go to STROBE.
  - Otherwise it stays in ISSUE with the grant held. A requester is not preempted mid-packet, even if it goes idle.
- **STROBE**
  - data_tx_wr=1 for exactly one cycle.
  - Go to WAIT.
- **WAIT**
  - On data_tx_ack, count is incremented.
  - If last_q or count==MAX_BURST:
    - rr_ptr<=g, grant<=0, active<=0, go to IDLE.
  - Else go to ISSUE.
- Acks arriving outside WAIT are ignored.
- tx_enable low does not abort a byte already in STROBE/WAIT. It only blocks the next consume in ISSUE and new grants in IDLE.
- Count is 8 bits and saturates at the compare, so there is no wrap.
- rr_ptr is $clog2(NUM_REQ) bits, reset value NUM_REQ-1, so requester 0 wins first after reset.
- NUM_REQ=1 degenerates to a fixed grant with burst limiting.

## Timing
- Reset values (all outputs): req_ready=0, data_tx=8'h00, data_tx_wr=0, grant=0, active=0. Internal: state=IDLE, count=0, rr_ptr=NUM_REQ-1.
- An asynchronous reset mid-byte drops everything immediately. The partial byte is the core's concern.
- Latency, valid seen in IDLE → data_tx_wr: 3 cycles, counted as IDLE→ISSUE→STROBE→wr.
  - 2 cycles if the grant is already held in ISSUE.
- data_tx is stable from STROBE until the next ISSUE consume.
- At most one req_ready bit is ever high, and only in ISSUE.
- Minimum byte period: 3 cycles plus the core's ack delay (consume, strobe, ack).
- Simultaneous req_valid edges are resolved purely by rr_ptr order.
- A requester dropping valid while in IDLE before the grant registers: the grant is still taken and the block waits in ISSUE. Requesters must hold valid until ready.

## Structure
- Shared header uart_defs.vh holds:
  - state encodings UART_ARB_IDLE/ISSUE/STROBE/WAIT (2 bits);
  - UART_ARB_MAX_REQ=8.
- Sub-module rr_arbiter(NUM_REQ): inputs req, ptr; output one-hot gnt. Purely combinational priority rotate. Instantiated once and reusable by other shared resources.

## Test plan
- Single requester 0 sends 3 bytes 0x41,0x42,0x43 with last on 0x43, ack 10 cycles after each wr:
  - exactly 3 wr pulses, data_tx in order;
  - grant=01 throughout, then 0;
  - rr_ptr=0.
- Both requesters valid at once after reset, 2-byte packets:
  - req 0 is served first, then req 1, then req 0 again;
  - packets never interleave.
- MAX_BURST=4, requester 0 streams 10 bytes with no last while requester 1 has 1 byte pending:
  - after 4 acks, grant moves to req 1 for its 1 byte, then back to req 0.
- tx_busy held high in ISSUE for 20 cycles:
  - no req_ready and no wr during that time;
  - the byte is consumed on the first cycle after tx_busy falls.
- tx_enable cleared while in WAIT:
  - the pending ack completes, no further req_ready is issued;
  - re-enabling resumes the same packet.
- rst_n asserted in WAIT:
  - all outputs are 0 the same cycle;
  - after release, a spurious data_tx_ack is ignored and arbitration restarts at req 0.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter slice.
//   - arb_state_t : 2-bit FSM encoding (IDLE / ISSUE / STROBE / WAIT)
//   - UART_ARB_MAX_REQ : upper bound on the number of requesters
//   - ptr_width() : width of a requester index, never below 1 bit so that
//                   the single-requester build still has a legal pointer
package uart_tx_arbiter_pkg;

  localparam int UART_ARB_MAX_REQ = 8;

  typedef enum logic [1:0] {
    UART_ARB_IDLE   = 2'd0,
    UART_ARB_ISSUE  = 2'd1,
    UART_ARB_STROBE = 2'd2,
    UART_ARB_WAIT   = 2'd3
  } arb_state_t;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin priority picker, reusable by any shared resource.
// Ports:
//   req [NUM_REQ] : request vector
//   ptr [PTR_W]   : index of the last winner; the scan starts at ptr+1
//   gnt [NUM_REQ] : one-hot winner, all-zero when no request is set
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int PTR_W = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic [PTR_W-1:0] idx;
  logic             found;

  // Walk the requesters starting just after the previous winner and wrapping;
  // the last position visited is the previous winner itself.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin scheduler sharing one UART transmitter between
// NUM_REQ byte-stream requesters.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/data/last   : per-requester byte stream (data at [8i+7:8i])
//   req_ready             : one-hot accept strobe, only while consuming
//   tx_enable, tx_busy    : UART control-register enable, core shifting
//   data_tx, data_tx_wr   : byte and one-cycle write strobe to the core
//   data_tx_ack           : core has taken the byte
//   grant, active         : current owner (one-hot) and grant-held flag
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   tx_enable,
  input  logic                   tx_busy,
  output logic [7:0]             data_tx,
  output logic                   data_tx_wr,
  input  logic                   data_tx_ack,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   active
);

  localparam int               PTR_W       = ptr_width(NUM_REQ);
  localparam logic [PTR_W-1:0] PTR_RESET   = PTR_W'(NUM_REQ - 1);
  localparam logic [7:0]       BURST_LIMIT = 8'(MAX_BURST);

  arb_state_t         state, state_next;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic [7:0]         count;
  logic [7:0]         count_inc;
  logic               last_q;
  logic [NUM_REQ-1:0] win;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;
  logic               start;
  logic               consume;
  logic               release_grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (win)
  );

  // Select the owner's stream; grant is one-hot so at most one term hits.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
        grant_idx = PTR_W'(i);
      end
    end
  end

  assign start     = (state == UART_ARB_IDLE) && tx_enable && (|req_valid);
  assign consume   = (state == UART_ARB_ISSUE) && sel_valid && tx_enable && !tx_busy;
  // The grant is dropped exactly when the count reaches the limit, so the
  // counter can never wrap.
  assign count_inc = count + 8'd1;
  assign release_grant = (state == UART_ARB_WAIT) && data_tx_ack &&
                         (last_q || (count_inc == BURST_LIMIT));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= UART_ARB_IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      UART_ARB_IDLE:   if (start)   state_next = UART_ARB_ISSUE;
      UART_ARB_ISSUE:  if (consume) state_next = UART_ARB_STROBE;
      UART_ARB_STROBE:              state_next = UART_ARB_WAIT;
      UART_ARB_WAIT: begin
        if (data_tx_ack) state_next = release_grant ? UART_ARB_IDLE : UART_ARB_ISSUE;
      end
      default:                      state_next = UART_ARB_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready  = consume ? grant : '0;
    data_tx_wr = (state == UART_ARB_STROBE);
  end

  // Grant, byte latch and burst bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant   <= '0;
      active  <= 1'b0;
      rr_ptr  <= PTR_RESET;
      count   <= '0;
      data_tx <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state)
        UART_ARB_IDLE: begin
          if (start) begin
            grant  <= win;
            active <= 1'b1;
            count  <= '0;
          end
        end
        UART_ARB_ISSUE: begin
          if (consume) begin
            data_tx <= sel_data;
            last_q  <= sel_last;
          end
        end
        UART_ARB_WAIT: begin
          if (data_tx_ack) count <= count_inc;
          if (release_grant) begin
            rr_ptr <= grant_idx;
            grant  <= '0;
            active <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
